// File: rtl/led_pkg.sv
// led_pkg: shared mode encoding for the LED pattern generator.
// Imported by led_channel and led_pattern_gen.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_PWM   = 2'd3
  } led_mode_e;

endpackage

// File: rtl/led_channel.sv
// led_channel: one LED output with mode/arg registers and a blink counter.
// Ports: clk, rst, we_i/mode_i/arg_i (config write), tick_i, sync_i,
//        pwm_i (shared PWM count), led_o (registered output).
module led_channel
  import led_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int PWM_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  led_mode_e        mode_i,
  input  logic [CNT_W-1:0] arg_i,
  input  logic             tick_i,
  input  logic             sync_i,
  input  logic [PWM_W-1:0] pwm_i,
  output logic             led_o
);

  led_mode_e        mode_q, mode_d;
  logic [CNT_W-1:0] arg_q, arg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_q, led_d;

  // A write restarts the phase and overrides any tick or sync.
  always_comb begin
    mode_d = mode_q;
    arg_d  = arg_q;
    cnt_d  = cnt_q;
    led_d  = led_q;
    if (we_i) begin
      mode_d = mode_i;
      arg_d  = arg_i;
      cnt_d  = '0;
      led_d  = (mode_i == LED_ON);
    end else begin
      if (sync_i) cnt_d = '0;
      unique case (mode_q)
        LED_OFF: led_d = 1'b0;
        LED_ON:  led_d = 1'b1;
        LED_BLINK: begin
          if (sync_i) begin
            led_d = 1'b0;
          end else if (tick_i) begin
            if (cnt_q == arg_q) begin
              cnt_d = '0;
              led_d = ~led_q;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        LED_PWM: led_d = (pwm_i < arg_q[PWM_W-1:0]);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= LED_OFF;
      arg_q  <= '0;
      cnt_q  <= '0;
      led_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      arg_q  <= arg_d;
      cnt_q  <= cnt_d;
      led_q  <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: CHANNELS LED drivers sharing a prescaler and PWM counter.
// Ports: clk, rst, cfg_we/cfg_ch/cfg_mode/cfg_arg (config), sync,
//        tick (base tick pulse), led (one bit per channel).
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int  CHANNELS = 4,
  parameter int  DIV      = 4,
  parameter int  CNT_W    = 8,
  parameter int  PWM_W    = 4,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_arg,
  input  logic                sync,
  output logic                tick,
  output logic [CHANNELS-1:0] led
);

  localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

  logic [PS_W-1:0]  presc_q, presc_d;
  logic [PWM_W-1:0] pwm_q, pwm_d;
  logic             tick_q, tick_d;

  // tick_q is high in exactly the cycle the prescaler sits at DIV-1,
  // except right after reset/sync where it is forced low.
  always_comb begin
    presc_d = presc_q;
    pwm_d   = pwm_q;
    tick_d  = 1'b0;
    if (sync) begin
      presc_d = '0;
      pwm_d   = '0;
    end else begin
      presc_d = (presc_q == PS_LAST) ? '0 : presc_q + 1'b1;
      tick_d  = (presc_d == PS_LAST);
      if (tick_q) pwm_d = pwm_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      pwm_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      pwm_q   <= pwm_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

  // Out-of-range channel numbers match no instance and are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic we;
    assign we = cfg_we && (cfg_ch == CH_W'(i));

    led_channel #(
      .CNT_W (CNT_W),
      .PWM_W (PWM_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .we_i   (we),
      .mode_i (led_mode_e'(cfg_mode)),
      .arg_i  (cfg_arg),
      .tick_i (tick_q),
      .sync_i (sync),
      .pwm_i  (pwm_q),
      .led_o  (led[i])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed scoreboard bench for led_pattern_gen.
// A second instance with DIV=1 checks the every-cycle tick case.
module tb_led_pattern_gen;

  localparam int NCH = 5;
  localparam int D   = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cfg_we = 1'b0;
  logic [2:0]     cfg_ch = '0;
  logic [1:0]     cfg_mode = '0;
  logic [7:0]     cfg_arg = '0;
  logic           sync = 1'b0;
  logic           tick;
  logic [NCH-1:0] led;
  logic           tick1;
  logic [0:0]     led1;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .CHANNELS (NCH),
    .DIV      (D),
    .CNT_W    (8),
    .PWM_W    (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_arg  (cfg_arg),
    .sync     (sync),
    .tick     (tick),
    .led      (led)
  );

  led_pattern_gen #(
    .CHANNELS (1),
    .DIV      (1),
    .CNT_W    (8),
    .PWM_W    (4)
  ) dut1 (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (1'b0),
    .cfg_ch   (1'b0),
    .cfg_mode (2'b00),
    .cfg_arg  (8'h00),
    .sync     (1'b0),
    .tick     (tick1),
    .led      (led1)
  );

  typedef struct {
    string          tag;
    logic [NCH-1:0] led;
    logic           tick;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc_n = 0;
  int   anchor = 0;
  int   mode_b[NCH];
  int   w_b[NCH];
  int   arg_b[NCH];
  bit   chk_d1 = 1'b0;
  int   hi;

  // Edges in (a,b] at which a base tick is consumed.
  function automatic int nticks(int a, int b);
    int n = 0;
    for (int x = a + 1; x <= b; x++)
      if (x > anchor && (x - anchor) % D == 0) n++;
    return n;
  endfunction

  function automatic logic exp_tick(int e);
    return (e > anchor) && ((e - anchor) % D == D - 1);
  endfunction

  function automatic logic [NCH-1:0] exp_led(int e);
    logic [NCH-1:0] v = '0;
    for (int i = 0; i < NCH; i++) begin
      case (mode_b[i])
        1: v[i] = 1'b1;
        2: begin
          int b;
          int n;
          b = (w_b[i] > anchor) ? w_b[i] : anchor;
          n = nticks(b, e) / (arg_b[i] + 1);
          v[i] = (n % 2) == 1;
        end
        3: begin
          int p;
          p = nticks(anchor, e - 1) % 16;
          v[i] = (e != w_b[i]) && (p < arg_b[i]);
        end
        default: v[i] = 1'b0;
      endcase
    end
    return v;
  endfunction

  task automatic chk();
    exp_t x;
    logic e1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_empty @%0d", cyc_n);
      return;
    end
    x = sb.pop_front();
    total++;
    assert (led === x.led) else begin
      bad++;
      $error("FAIL %s led @%0d: got %b want %b",
             x.tag, cyc_n, led, x.led);
    end
    total++;
    assert (tick === x.tick) else begin
      bad++;
      $error("FAIL %s tick @%0d: got %b want %b",
             x.tag, cyc_n, tick, x.tick);
    end
    if (chk_d1) begin
      e1 = !rst;
      total++;
      assert (tick1 === e1) else begin
        bad++;
        $error("FAIL div1_tick @%0d: got %b want %b",
               cyc_n, tick1, e1);
      end
    end
  endtask

  task automatic step(string tag);
    exp_t x;
    x.tag  = tag;
    x.led  = exp_led(cyc_n + 1);
    x.tick = exp_tick(cyc_n + 1);
    sb.push_back(x);
    @(posedge clk);
    #1;
    cyc_n++;
    cfg_we = 1'b0;
    sync   = 1'b0;
    chk();
  endtask

  task automatic idle(int n, string tag);
    repeat (n) step(tag);
  endtask

  task automatic align(int ph);
    while (((cyc_n + 1 - anchor) % D) != ph) step("align");
  endtask

  task automatic wr(int ch, int m, int a, string tag);
    cfg_we   = 1'b1;
    cfg_ch   = 3'(ch);
    cfg_mode = 2'(m);
    cfg_arg  = 8'(a);
    if (ch < NCH) begin
      mode_b[ch] = m;
      arg_b[ch]  = a;
      w_b[ch]    = cyc_n + 1;
    end
    step(tag);
  endtask

  task automatic do_sync();
    sync   = 1'b1;
    anchor = cyc_n + 1;
    step("sync");
  endtask

  task automatic do_rst(string tag);
    rst    = 1'b1;
    anchor = cyc_n + 1;
    for (int i = 0; i < NCH; i++) mode_b[i] = 0;
    step(tag);
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin
      mode_b[i] = 0;
      w_b[i]    = 0;
      arg_b[i]  = 0;
    end

    chk_d1 = 1'b1;
    repeat (3) do_rst("reset");
    rst = 1'b0;
    idle(12, "tick");
    chk_d1 = 1'b0;

    wr(3, 1, 0, "on3");
    wr(1, 1, 0, "on1");
    wr(1, 0, 0, "off1");
    wr(3, 0, 0, "off3");
    wr(5, 1, 0, "ch5");
    wr(7, 1, 0, "ch7");
    idle(2, "oor");

    align(1);
    wr(0, 2, 1, "blink0");
    idle(64, "blink");

    align(0);
    wr(0, 2, 1, "blink_tick");
    idle(16, "restart");

    align(2);
    idle(4, "gap");
    wr(2, 2, 1, "blink2");
    idle(24, "oop");

    do_sync();
    repeat (40) begin
      step("synced");
      total++;
      assert (led[0] === led[2]) else begin
        bad++;
        $error("FAIL sync_phase @%0d: got %b want %b",
               cyc_n, led[2], led[0]);
      end
    end

    wr(2, 3, 4, "pwm4");
    idle(64, "pwm");
    hi = 0;
    repeat (64) begin
      step("pwm");
      hi += int'(led[2]);
    end
    total++;
    assert (hi == 16) else begin
      bad++;
      $error("FAIL pwm4_duty: got %0d want %0d", hi, 16);
    end

    wr(2, 3, 0, "pwm0");
    hi = 0;
    repeat (64) begin
      step("pwm0");
      hi += int'(led[2]);
    end
    total++;
    assert (hi == 0) else begin
      bad++;
      $error("FAIL pwm0_duty: got %0d want %0d", hi, 0);
    end

    wr(1, 1, 0, "on1b");
    idle(6, "mix");
    do_rst("rst_mid");
    rst = 1'b0;
    idle(16, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised multi-channel LED driver: successor to the single-output blinker, driving `CHANNELS` LEDs, each independently configured as OFF, ON, BLINK (programmable half-period) or PWM (programmable duty). A shared clock prescaler generates a base tick; a simple write port configures one channel per cycle, and a `sync` strobe realigns all channel phases. It sits between a control register block and the board LED pins.

## Interface
- `CHANNELS`, default 4: number of LED outputs, ≥1.
- `DIV`, default 4: clk cycles per base tick, ≥1.
- `CNT_W`, default 8: width of per-channel argument and blink counter.
- `PWM_W`, default 4: PWM counter width, ≤ `CNT_W`; PWM frame = 2^PWM_W ticks.
- Derived `CH_W` = max(1, clog2(CHANNELS)).

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  write strobe, one channel per cycle.
- `cfg_ch`  in  CH_W  target channel; values ≥ `CHANNELS` ignored.
- `cfg_mode`  in  2  0=OFF, 1=ON, 2=BLINK, 3=PWM.
- `cfg_arg`  in  CNT_W  BLINK: half-period minus one, in ticks; PWM: duty in low `PWM_W` bits.
- `sync`  in  1  phase-realign strobe.
- `tick`  out  1  one-cycle pulse per base tick.
- `led`  out  CHANNELS  registered LED outputs, bit i = channel i.

## Operation
- Reset: `led`=0, `tick`=0, all modes OFF, all args 0, prescaler, PWM counter and blink counters 0.
- Prescaler counts 0..DIV-1, wraps; `tick`=1 (registered) in the cycle the count equals DIV-1. DIV=1 → `tick` high every cycle after reset.
- Shared PWM counter (`PWM_W` bits) increments on each tick, wraps 2^PWM_W-1 → 0.
- Per channel, every cycle:
  - OFF: `led[i]`←0. ON: `led[i]`←1.
  - BLINK: on tick, if cnt==arg then cnt←0 and `led[i]` toggles, else cnt←cnt+1. arg=0 → toggle every tick.
  - PWM: `led[i]`←(pwm_cnt < arg[PWM_W-1:0]); duty 0 = always off; max duty = (2^PWM_W-1)/2^PWM_W.
- Config write to valid channel: mode, arg latched; cnt←0; `led[i]`←1 if new mode ON, else 0. Effective from the following cycle.
- `sync`: prescaler, PWM counter and all blink counters ←0; `led` of BLINK channels ←0; `tick` ←0 that cycle. OFF/ON/PWM channel outputs follow normal rules.

## Timing
- `led` changes one cycle after the tick (or write) that causes it; PWM output lags the PWM counter by one cycle.
- BLINK full period = 2·(arg+1)·DIV cycles.
- Write and tick on same channel same cycle: write wins (tick ignored for that channel).
- Write and `sync` same cycle: both apply; written channel takes written config with cnt=0.
- `rst` has priority over `cfg_we` and `sync`; reset mid-blink returns to reset state in the next cycle.
- Writing identical config to a running channel still restarts its phase.

## Structure
- Package `led_pkg`: mode constants (`LED_OFF`, `LED_ON`, `LED_BLINK`, `LED_PWM`) and the 2-bit mode type.
- Sub-module `led_channel` (mode/arg registers, blink counter, output flop), instanced `CHANNELS` times via generate; prescaler, PWM counter and write decode in the top.

## Test plan
- Reset: hold `rst` 3 cycles -> `led`=0000, `tick`=0; after release with DIV=4, `tick` pulses on cycles 4, 8, 12.
- ON/OFF: write ch1 ON -> `led[1]`=1 next cycle; write ch1 OFF -> 0 next cycle; other bits unchanged.
- BLINK: DIV=4, write ch0 BLINK arg=1 -> `led[0]` toggles every 8 cycles, 16-cycle period over 64 cycles.
- PWM: write ch2 PWM arg=4, PWM_W=4 -> `led[2]` high 4 ticks of every 16; arg=0 -> never high.
- Boundaries: `cfg_ch`=5 with CHANNELS=4 -> no change; write coinciding with tick on ch0 -> counter restarts at 0.
- `sync`/reset mid-operation: pulse `sync` during BLINK -> two channels previously out of phase toggle together afterwards; `rst` mid-blink -> all outputs 0 next cycle, modes OFF.
